cell_pos_stream_reader: RTL

- Consumer of one position-cell RAM: drives its read port and streams the cell's particles to the force-evaluation pipeline with valid/ready flow control.
- Address 0 holds the particle count; particles occupy addresses 1..N.
- Absorbs the RAM's fixed 2-cycle read latency with a credit-limited skid FIFO, so downstream backpressure never drops a word.

---
 rtl/cell_pos_stream_reader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cell_pos_stream_reader.sv
// Reads one position cell from its RAM (count at address 0, particles at 1..N) and
// streams the particles downstream through a credit-limited skid FIFO.
module cell_pos_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cnt_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pos;
    logic [ADDR_WIDTH-1:0] pid;
    logic                  last;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            pipe_q, pipe_d;
  logic [ADDR_WIDTH-1:0] pid0_q, pid0_d, pid1_q, pid1_d;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  pop, push, issue_ok, cnt_over;
  logic [CNT_W-1:0]      cnt_after, wr_idx;
  logic [ADDR_WIDTH-1:0] cnt_word, n_cap;
  entry_t                push_ent;

  assign pop       = vld_q[0] & out_ready;
  assign push      = pipe_q[1];
  assign wr_idx    = cnt_q - CNT_W'(pop);
  assign cnt_after = wr_idx + CNT_W'(push);
  assign cnt_word  = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over  = cnt_word > MAX_N;
  assign n_cap     = cnt_over ? MAX_N : cnt_word;
  assign push_ent  = '{pos: mem_q, pid: pid1_q, last: (pid1_q == n_q)};

  // Issue only if every read already committed still has a FIFO slot after this cycle.
  assign issue_ok = (CRD_W'(cnt_after) + CRD_W'(rden_q) + CRD_W'(pipe_q[0]))
                    < CRD_W'(FIFO_DEPTH);

  // Particle reads in flight; the count read (address 0) never enters the FIFO.
  always_comb begin
    pipe_d = {pipe_q[0], rden_q & (addr_q != '0)};
    pid0_d = addr_q;
    pid1_d = pid0_q;
  end

  // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
  always_comb begin
    fifo_d = fifo_q;
    vld_d  = vld_q;
    cnt_d  = cnt_after;
    if (pop) begin
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      vld_d[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          fifo_d[i] = push_ent;
          vld_d[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    n_d      = n_q;
    rd_ptr_d = rd_ptr_q;
    rden_d   = 1'b0;
    addr_d   = addr_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_CNT;
          rden_d  = 1'b1;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_RD_CNT: begin
        state_d = S_WAIT_CNT;
        wait_d  = 1'b0;
      end
      S_WAIT_CNT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          n_d = n_cap;
          if (cnt_over) err_d = 1'b1;
          if (n_cap == '0) begin
            state_d = S_DONE;
          end else begin
            // First particle read goes out with the count decision; the FIFO is empty.
            rden_d   = 1'b1;
            addr_d   = ADDR_WIDTH'(1);
            rd_ptr_d = ADDR_WIDTH'(2);
            state_d  = (n_cap == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (issue_ok) begin
          rden_d   = 1'b1;
          addr_d   = rd_ptr_q;
          rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          if (rd_ptr_q == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!rden_q && !pipe_q[0] && (cnt_after == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RD_CNT) || (state_d == S_WAIT_CNT) ||
             (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wait_q   <= 1'b0;
      n_q      <= '0;
      rd_ptr_q <= '0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      pipe_q   <= '0;
      pid0_q   <= '0;
      pid1_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      n_q      <= n_d;
      rd_ptr_q <= rd_ptr_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      pipe_q   <= pipe_d;
      pid0_q   <= pid0_d;
      pid1_q   <= pid1_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_rden    = rden_q;
  assign mem_wren    = 1'b0;
  assign out_valid   = vld_q[0];
  assign out_pos     = fifo_q[0].pos;
  assign out_pid     = fifo_q[0].pid;
  assign out_last    = fifo_q[0].last;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt_err     = err_q;

endmodule
